// File: rtl/gf180mcu_tie_monitor_pkg.sv
// Shared types and constants for the tie-net integrity monitor.
package gf180mcu_tie_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMING   = 2'd1,
    ST_MONITOR  = 2'd2,
    ST_CLEARING = 2'd3
  } state_e;

  localparam int                   MISCNT_W   = 8;
  localparam logic [MISCNT_W-1:0]  MISCNT_MAX = 8'd255;
  localparam int                   CNT_W      = 4;

  function automatic logic [MISCNT_W-1:0] sat_inc(input logic [MISCNT_W-1:0] v);
    if (v == MISCNT_MAX) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/gf180mcu_tie_monitor_chan.sv
// One monitored tie net: consecutive-mismatch counter plus sticky fault flag.
module gf180mcu_tie_monitor_chan
  import gf180mcu_tie_monitor_pkg::*;
#(
  parameter int THRESH = 4
) (
  input  logic i_clk,
  input  logic i_rn,
  input  logic i_clr,
  input  logic i_run,
  input  logic i_mismatch,
  output logic o_flag,
  output logic o_flag_nxt
);

  localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_flag;
  logic             w_flag_nxt;

  // Clear beats detection; outside the run window the counter is held at zero.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_flag_nxt = r_flag;
    if (i_clr) begin
      w_cnt_nxt  = {CNT_W{1'b0}};
      w_flag_nxt = 1'b0;
    end else if (i_run && i_mismatch) begin
      if (r_cnt != THR) begin
        w_cnt_nxt = r_cnt + CNT_ONE;
      end else begin
        w_cnt_nxt = r_cnt;
      end
      if (w_cnt_nxt == THR) begin
        w_flag_nxt = 1'b1;
      end else begin
        w_flag_nxt = r_flag;
      end
    end else begin
      w_cnt_nxt  = {CNT_W{1'b0}};
      w_flag_nxt = r_flag;
    end
  end

  // Counter and sticky flag registers.
  always_ff @(posedge i_clk) begin
    if (!i_rn) begin
      r_cnt  <= {CNT_W{1'b0}};
      r_flag <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_flag <= w_flag_nxt;
    end
  end

  assign o_flag     = r_flag;
  assign o_flag_nxt = w_flag_nxt;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__tie_monitor.sv
// Tie-net integrity monitor top: FSM, sample pipeline, MISCNT and clear handshake.
// GF180MCU_TIE_MONITOR_SYNC_EN selects a two-flop synchronizer on Z (default: one capture flop).
module gf180mcu_fd_sc_mcu7t5v0__tie_monitor
  import gf180mcu_tie_monitor_pkg::*;
#(
  parameter int             N      = 8,
  parameter logic [N-1:0]   EXPECT = {N{1'b1}},
  parameter int             THRESH = 4
) (
  input  logic                CLK,
  input  logic                RN,
  inout  wire                 VDD,
  inout  wire                 VSS,
  input  logic                EN,
  input  logic [N-1:0]        Z,
  input  logic                CLR,
  output logic                CLR_ACK,
  output logic                FAULT,
  output logic [N-1:0]        FAULT_MASK,
  output logic [MISCNT_W-1:0] MISCNT
);

  logic [N-1:0] r_samp;

`ifdef GF180MCU_TIE_MONITOR_SYNC_EN
  localparam int DEPTH = 2;
  logic [N-1:0] r_sync1;

  // Two-flop synchronizer on the tie nets.
  always_ff @(posedge CLK) begin
    if (!RN) begin
      r_sync1 <= {N{1'b0}};
      r_samp  <= {N{1'b0}};
    end else begin
      r_sync1 <= Z;
      r_samp  <= r_sync1;
    end
  end
`else
  localparam int DEPTH = 1;

  // Single capture flop on the tie nets.
  always_ff @(posedge CLK) begin
    if (!RN) begin
      r_samp <= {N{1'b0}};
    end else begin
      r_samp <= Z;
    end
  end
`endif

  localparam logic [1:0] ARM_LAST = 2'(DEPTH - 1);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [1:0]            r_arm_cnt;
  logic                  w_clr_entry;
  logic                  w_run;
  logic [N-1:0]          w_mismatch;
  logic [N-1:0]          w_mask_nxt;
  logic [MISCNT_W-1:0]   r_miscnt;
  logic                  r_fault;
  logic                  r_clr_ack;
  logic                  w_unused_supply;

  assign w_unused_supply = VDD ^ VSS;
  assign w_mismatch      = r_samp ^ EXPECT;

  // Next-state logic; a clear request pre-empts every other transition.
  always_comb begin
    w_state_nxt = r_state;
    w_clr_entry = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (CLR) begin
          w_state_nxt = ST_CLEARING;
          w_clr_entry = 1'b1;
        end else if (EN) begin
          w_state_nxt = ST_ARMING;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ARMING: begin
        if (CLR) begin
          w_state_nxt = ST_CLEARING;
          w_clr_entry = 1'b1;
        end else if (!EN) begin
          w_state_nxt = ST_IDLE;
        end else if (r_arm_cnt == ARM_LAST) begin
          w_state_nxt = ST_MONITOR;
        end else begin
          w_state_nxt = ST_ARMING;
        end
      end
      ST_MONITOR: begin
        if (CLR) begin
          w_state_nxt = ST_CLEARING;
          w_clr_entry = 1'b1;
        end else if (!EN) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_MONITOR;
        end
      end
      ST_CLEARING: begin
        if (CLR) begin
          w_state_nxt = ST_CLEARING;
        end else if (EN) begin
          w_state_nxt = ST_ARMING;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Samples count only while staying in MONITOR, so leaving it zeroes the counters.
  assign w_run = (r_state == ST_MONITOR) && (w_state_nxt == ST_MONITOR);

  // State register and arming-delay counter.
  always_ff @(posedge CLK) begin
    if (!RN) begin
      r_state   <= ST_IDLE;
      r_arm_cnt <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_ARMING) && (w_state_nxt == ST_ARMING)) begin
        r_arm_cnt <= r_arm_cnt + 2'd1;
      end else begin
        r_arm_cnt <= 2'd0;
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_chan
    gf180mcu_tie_monitor_chan #(.THRESH(THRESH)) u_chan (
      .i_clk      (CLK),
      .i_rn       (RN),
      .i_clr      (w_clr_entry),
      .i_run      (w_run),
      .i_mismatch (w_mismatch[g]),
      .o_flag     (FAULT_MASK[g]),
      .o_flag_nxt (w_mask_nxt[g])
    );
  end

  // Registered status outputs: FAULT tracks the mask on the same edge.
  always_ff @(posedge CLK) begin
    if (!RN) begin
      r_miscnt  <= {MISCNT_W{1'b0}};
      r_fault   <= 1'b0;
      r_clr_ack <= 1'b0;
    end else begin
      r_fault   <= |w_mask_nxt;
      r_clr_ack <= (w_state_nxt == ST_CLEARING);
      if (w_clr_entry) begin
        r_miscnt <= {MISCNT_W{1'b0}};
      end else if (w_run && (|w_mismatch)) begin
        r_miscnt <= sat_inc(r_miscnt);
      end else begin
        r_miscnt <= r_miscnt;
      end
    end
  end

  assign CLR_ACK = r_clr_ack;
  assign FAULT   = r_fault;
  assign MISCNT  = r_miscnt;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__tie_monitor.sv
// Self-checking bench for the tie-net monitor with a behavioural reference model.
module tb_gf180mcu_fd_sc_mcu7t5v0__tie_monitor;

`ifdef GF180MCU_TIE_MONITOR_SYNC_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam int THRESH = 4;
  localparam int M_IDLE = 0, M_ARM = 1, M_MON = 2, M_CLR = 3;

  logic       clk = 1'b0;
  logic       rn, en, clr;
  logic [7:0] z;
  wire        vdd = 1'b1;
  wire        vss = 1'b0;
  logic       clr_ack, fault;
  logic [7:0] fault_mask, miscnt;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int         m_mode;
  int         m_arm;
  int         m_run [8];
  logic [7:0] m_mask;
  int         m_mis;
  logic       m_ack;
  logic [7:0] m_pipe [$];
  logic [7:0] exp_pat = 8'hFF;

  gf180mcu_fd_sc_mcu7t5v0__tie_monitor #(.N(8), .EXPECT(8'hFF), .THRESH(THRESH)) dut (
    .CLK(clk), .RN(rn), .VDD(vdd), .VSS(vss), .EN(en), .Z(z), .CLR(clr),
    .CLR_ACK(clr_ack), .FAULT(fault), .FAULT_MASK(fault_mask), .MISCNT(miscnt)
  );

  always #5 clk = ~clk;

  wire [18:0] obs = {fault, fault_mask, clr_ack, miscnt};

  function automatic logic [18:0] exp_vec();
    return {|m_mask, m_mask, m_ack, 8'(m_mis)};
  endfunction

  task automatic model_step();
    logic [7:0] smp;
    if (!rn) begin
      m_mode = M_IDLE; m_arm = 0; m_mask = 8'h00; m_mis = 0; m_ack = 1'b0;
      for (int i = 0; i < 8; i++) m_run[i] = 0;
      m_pipe.delete();
      for (int i = 0; i < DEPTH; i++) m_pipe.push_back(8'h00);
    end else begin
      smp = m_pipe.pop_front();
      m_pipe.push_back(z);
      if (m_mode == M_MON && en && !clr) begin
        for (int i = 0; i < 8; i++) begin
          if (smp[i] !== exp_pat[i]) begin
            if (m_run[i] < THRESH) m_run[i]++;
            if (m_run[i] == THRESH) m_mask[i] = 1'b1;
          end else begin
            m_run[i] = 0;
          end
        end
        if (smp != exp_pat && m_mis < 255) m_mis++;
      end else begin
        for (int i = 0; i < 8; i++) m_run[i] = 0;
      end
      if (clr && m_mode != M_CLR) begin
        m_mask = 8'h00; m_mis = 0; m_ack = 1'b1; m_mode = M_CLR;
        for (int i = 0; i < 8; i++) m_run[i] = 0;
      end else begin
        case (m_mode)
          M_IDLE: if (en) begin m_mode = M_ARM; m_arm = DEPTH; end
          M_ARM: begin
            if (!en) m_mode = M_IDLE;
            else begin
              m_arm--;
              if (m_arm == 0) m_mode = M_MON;
            end
          end
          M_MON: if (!en) m_mode = M_IDLE;
          default: begin
            if (!clr) begin
              m_ack = 1'b0;
              if (en) begin m_mode = M_ARM; m_arm = DEPTH; end
              else m_mode = M_IDLE;
            end
          end
        endcase
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rn = 1'b0; en = 1'b0; clr = 1'b0; z = 8'h00;
    tick();
    total++;
    if (obs !== 19'h0) begin
      bad++; $display("FAIL reset outputs got=%h want=%h", obs, 19'h0);
    end
    total++;
    if (obs !== exp_vec()) begin
      bad++; $display("FAIL reset_model got=%h want=%h", obs, exp_vec());
    end
  endtask

  task automatic test_clean();
    rn = 1'b1; en = 1'b1; z = 8'hFF;
    for (int k = 0; k < 20; k++) begin
      tick();
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL clean_model cyc=%0d got=%h want=%h", k, obs, exp_vec());
      end
    end
    total++;
    if (fault !== 1'b0 || miscnt !== 8'd0) begin
      bad++; $display("FAIL clean fault=%b miscnt=%0d want 0/0", fault, miscnt);
    end
  endtask

  task automatic test_stuck();
    z = 8'hFB;
    for (int k = 1; k <= 10; k++) begin
      tick();
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL stuck_model edge=%0d got=%h want=%h", k, obs, exp_vec());
      end
      if (k == DEPTH + THRESH - 1) begin
        total++;
        if (fault_mask !== 8'h00 || fault !== 1'b0) begin
          bad++; $display("FAIL stuck_early edge=%0d mask=%h fault=%b want 00/0", k, fault_mask, fault);
        end
      end
      if (k >= DEPTH + THRESH) begin
        total++;
        if (fault_mask !== 8'h04 || fault !== 1'b1) begin
          bad++; $display("FAIL stuck_fault edge=%0d mask=%h fault=%b want 04/1", k, fault_mask, fault);
        end
      end
      total++;
      if (miscnt !== 8'((k > DEPTH) ? k - DEPTH : 0)) begin
        bad++; $display("FAIL stuck_miscnt edge=%0d got=%0d want=%0d", k, miscnt, (k > DEPTH) ? k - DEPTH : 0);
      end
    end
  endtask

  task automatic test_clear();
    clr = 1'b1;
    tick();
    total++;
    if (clr_ack !== 1'b1 || fault_mask !== 8'h00 || miscnt !== 8'd0 || fault !== 1'b0) begin
      bad++; $display("FAIL clr_entry ack=%b mask=%h mis=%0d want 1/00/0", clr_ack, fault_mask, miscnt);
    end
    tick();
    total++;
    if (clr_ack !== 1'b1) begin
      bad++; $display("FAIL clr_hold ack=%b want 1", clr_ack);
    end
    clr = 1'b0;
    tick();
    total++;
    if (clr_ack !== 1'b0 || obs !== exp_vec()) begin
      bad++; $display("FAIL clr_exit got=%h want=%h", obs, exp_vec());
    end
    for (int k = 0; k < DEPTH; k++) begin
      tick();
      total++;
      if (miscnt !== 8'd0) begin
        bad++; $display("FAIL clr_arming k=%0d miscnt=%0d want 0", k, miscnt);
      end
    end
    tick();
    total++;
    if (miscnt !== 8'd1) begin
      bad++; $display("FAIL clr_rearm miscnt=%0d want 1", miscnt);
    end
  endtask

  task automatic test_glitch();
    z = 8'hFF;
    for (int k = 0; k < 4; k++) tick();
    clr = 1'b1; tick();
    clr = 1'b0; tick();
    for (int k = 0; k < DEPTH + 2; k++) tick();
    for (int k = 0; k < 13; k++) begin
      z = (k < 3) ? 8'hFB : 8'hFF;
      tick();
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL glitch_model k=%0d got=%h want=%h", k, obs, exp_vec());
      end
    end
    total++;
    if (fault !== 1'b0 || miscnt !== 8'd3) begin
      bad++; $display("FAIL glitch fault=%b miscnt=%0d want 0/3", fault, miscnt);
    end
  endtask

  task automatic test_collision();
    z = 8'hFB;
    for (int k = 1; k < DEPTH + THRESH; k++) tick();
    total++;
    if (fault_mask !== 8'h00) begin
      bad++; $display("FAIL collide_pre mask=%h want 00", fault_mask);
    end
    clr = 1'b1;
    tick();
    total++;
    if (fault_mask !== 8'h00 || fault !== 1'b0 || clr_ack !== 1'b1) begin
      bad++; $display("FAIL collide mask=%h fault=%b ack=%b want 00/0/1", fault_mask, fault, clr_ack);
    end
    clr = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rn  = ($urandom_range(0, 59) != 0);
      en  = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 24) == 0) ? 1'b1 : (clr && $urandom_range(0, 2) != 0);
      z   = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
      tick();
      total++;
      if (obs !== exp_vec()) begin
        bad++; $display("FAIL random_model k=%0d got=%h want=%h", k, obs, exp_vec());
      end
    end
  endtask

  task automatic test_saturation();
    rn = 1'b0; en = 1'b0; clr = 1'b0; z = 8'h00;
    tick();
    rn = 1'b1; en = 1'b1;
    for (int k = 0; k < 300 + DEPTH + 1; k++) tick();
    total++;
    if (miscnt !== 8'd255 || fault_mask !== 8'hFF || obs !== exp_vec()) begin
      bad++; $display("FAIL saturate miscnt=%0d mask=%h want 255/ff", miscnt, fault_mask);
    end
    en = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    total++;
    if (miscnt !== 8'd255 || fault_mask !== 8'hFF || fault !== 1'b1) begin
      bad++; $display("FAIL idle_retain miscnt=%0d mask=%h want 255/ff", miscnt, fault_mask);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_stuck();
    test_clear();
    test_glitch();
    test_collision();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__tie_monitor.md
# gf180mcu_fd_sc_mcu7t5v0__tie_monitor

Sequential integrity monitor for tie-off nets: samples N tie-level nets driven by the library's tie-high/tie-low cells, compares them against a fixed expected pattern, and latches a sticky per-net fault after a programmable run of consecutive mismatches. It sits beside the tie cells in always-on logic and reports to the power/test controller through a four-phase clear handshake.

## Interface
- N, 8, number of monitored tie nets
- EXPECT, {N{1'b1}}, expected level per net (1 = tie-high, 0 = tie-low)
- THRESH, 4, consecutive mismatching samples to declare a fault (1..15)
- CLK  input  1  rising-edge clock
- RN  input  1  reset, synchronous, active-low
- VDD  inout  1  supply
- VSS  inout  1  ground
- EN  input  1  monitor enable
- Z  input  N  tie nets under test
- CLR  input  1  clear request (four-phase)
- CLR_ACK  output  1  clear acknowledge
- FAULT  output  1  OR of FAULT_MASK
- FAULT_MASK  output  N  sticky per-net fault flags
- MISCNT  output  8  saturating count of sample cycles with any mismatch

## Operation
- States: IDLE, ARMING, MONITOR, CLEARING.
- Reset (RN low at a CLK edge): state IDLE, FAULT=0, FAULT_MASK=0, CLR_ACK=0, MISCNT=0, sample pipeline and per-net counters cleared. Reset mid-handshake or mid-count aborts it.
- IDLE: counters held at 0. EN=1 → ARMING.
- ARMING: waits for the sample pipeline to fill (2 cycles with sync, 1 without), then → MONITOR. EN=0 → IDLE.
- MONITOR: per net, mismatch = sampled Z[i] != EXPECT[i]. A mismatch increments a 4-bit counter, saturating at THRESH. A match zeroes it. The counter reaching THRESH sets FAULT_MASK[i] on the same edge. MISCNT increments, saturating at 255, on each sample with any mismatch. EN=0 → IDLE with counters zeroed; FAULT_MASK and MISCNT retained.
- FAULT_MASK is cleared only by reset or CLR.
- CLR=1 in any state → CLEARING. On the entry edge: FAULT_MASK=0, MISCNT=0, counters 0, CLR_ACK=1.
- CLEARING: CLR_ACK held while CLR=1. When CLR=0, the next edge drops CLR_ACK and goes → ARMING if EN=1, else → IDLE.
- Simultaneous clear and fault detection: clear wins and the mask stays 0.
- EN toggling during CLEARING is ignored until exit.

## Timing
- All outputs are registered.
- With sync: mismatched Z is captured at edge 1. Counter reaches 1 at edge 3. FAULT_MASK/FAULT assert after edge 2+THRESH.
- Without sync: FAULT asserts after edge 1+THRESH.
- MISCNT lags the captured sample by the same pipeline depth.
- CLR_ACK rises one edge after CLR is sampled high and falls one edge after CLR is sampled low.

## Configuration
- GF180MCU_TIE_MONITOR_SYNC_EN defined: Z passes through a two-flop synchronizer; pipeline depth 2; ARMING lasts 2 cycles.
- Not defined: Z is captured by a single register; depth 1; ARMING lasts 1 cycle.
- All other behaviour is identical.

## Structure
- Shared package `gf180mcu_tie_monitor_pkg`:
  - state enum (IDLE, ARMING, MONITOR, CLEARING)
  - MISCNT width constant (8) and saturation value (255)
  - counter width constant (4)
- One sub-module, `gf180mcu_tie_monitor_chan`: per-net mismatch counter plus sticky flag. Instantiated N times by a generate loop.
- Top level holds the FSM, sample pipeline, MISCNT and handshake.

## Test plan
- Reset: RN=0 for one edge with Z=8'h00 → FAULT=0, FAULT_MASK=8'h00, CLR_ACK=0, MISCNT=0; state IDLE.
- Clean run (N=8, EXPECT=8'hFF, THRESH=4, sync on): EN=1, Z=8'hFF for 20 cycles → FAULT=0, MISCNT=0.
- Stuck net: Z=8'hFB from edge 1 → FAULT_MASK=8'h04 and FAULT=1 after edge 6. MISCNT=1 after edge 3, increasing by 1 per cycle.
- Glitch: Z=8'hFB for 3 cycles, then 8'hFF → FAULT=0, MISCNT=3.
- Clear handshake after a fault:
  - CLR=1 → next edge CLR_ACK=1, FAULT_MASK=0, MISCNT=0.
  - CLR=0 → next edge CLR_ACK=0, ARMING; MONITOR two edges later.
  - Fault detection on the CLR entry edge → mask stays 0.
- Saturation: Z=8'h00 for 300 sample cycles → MISCNT=255, FAULT_MASK=8'hFF. EN=0 → IDLE with both retained.
